qoi_mem_arbiter: RTL and testbench

QOI_MEM_ARBITER -- requirements
Module: qoi_mem_arbiter

---
 rtl/qoi_types.sv | 18 +
 rtl/qoi_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_qoi_mem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qoi_types.sv
// Shared types for the QOI buffer arbiter: FSM states, read-return tag and
// the default buffer address type.
package qoi_types;

    typedef logic [9:0] addr_t;

    typedef enum logic [1:0] {
        CPU_PRI   = 2'd0,
        ACC_BURST = 2'd1,
        CPU_SLOT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        TAG_CPU = 1'b0,
        TAG_ACC = 1'b1
    } req_tag_t;

endpackage

// File: rtl/qoi_mem_arbiter.sv
// Shares one synchronous-read buffer RAM between the 6502 and the QOI
// accelerator. The CPU normally has priority, the accelerator is protected
// from starvation and may lock short bursts, and read data is routed back
// one cycle later using a registered source tag.
module qoi_mem_arbiter
    import qoi_types::*;
#(
    parameter int ADDR_W     = $bits(addr_t),
    parameter int STARVE_MAX = 4,
    parameter int BURST_MAX  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_rdy,
    input  logic              acc_req,
    input  logic              acc_we,
    input  logic              acc_lock,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [7:0]        acc_wdata,
    output logic              acc_gnt,
    output logic              acc_rvalid,
    output logic [7:0]        acc_rdata,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              conflict
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [BW-1:0] BURST_LIM  = BW'(BURST_MAX);

    arb_state_t    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [BW-1:0] burst_inc;
    logic          rd_valid_q, rd_valid_d;
    req_tag_t      rd_tag_q, rd_tag_d;
    logic [7:0]    hold_q, hold_d;
    logic          pri_cpu, pri_acc;
    logic          cpu_win, acc_win;
    logic          cpu_gnt;

    // CPU-priority decision with the starvation override
    always_comb begin
        pri_acc = acc_req && (!cpu_req || (starve_q == STARVE_LIM));
        pri_cpu = cpu_req && !pri_acc;
    end

    // Next-state and winner selection; a burst that stays saturated until the
    // CPU asks hands the CPU this cycle directly instead of via CPU_SLOT
    always_comb begin
        state_d   = state_q;
        burst_d   = burst_q;
        cpu_win   = 1'b0;
        acc_win   = 1'b0;
        burst_inc = (burst_q == BURST_LIM) ? burst_q : burst_q + BW'(1);
        case (state_q)
            CPU_SLOT: begin
                cpu_win = cpu_req;
                state_d = CPU_PRI;
                burst_d = '0;
            end
            ACC_BURST: begin
                if (acc_req && acc_lock) begin
                    if ((burst_q == BURST_LIM) && cpu_req) begin
                        cpu_win = 1'b1;
                        state_d = CPU_PRI;
                        burst_d = '0;
                    end else begin
                        acc_win = 1'b1;
                        burst_d = burst_inc;
                        if ((burst_inc == BURST_LIM) && cpu_req) begin
                            state_d = CPU_SLOT;
                            burst_d = '0;
                        end
                    end
                end else begin
                    cpu_win = pri_cpu;
                    acc_win = pri_acc;
                    state_d = CPU_PRI;
                    burst_d = '0;
                end
            end
            default: begin
                cpu_win = pri_cpu;
                acc_win = pri_acc;
                if (pri_acc && acc_lock) begin
                    state_d = ACC_BURST;
                    burst_d = BW'(1);
                end
            end
        endcase
    end

    // RAM port mirrors the winner; reset suppresses every grant immediately
    always_comb begin
        acc_gnt   = acc_win & rst;
        cpu_gnt   = cpu_win & rst;
        ram_cs    = acc_gnt | cpu_gnt;
        ram_we    = 1'b0;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        if (acc_gnt) begin
            ram_we    = acc_we;
            ram_addr  = acc_addr;
            ram_wdata = acc_wdata;
        end else if (cpu_gnt) begin
            ram_we = cpu_we;
        end
        cpu_rdy  = !(cpu_req && acc_gnt);
        conflict = cpu_req & acc_req;
    end

    // Starvation counting and read-return routing
    always_comb begin
        starve_d = '0;
        if (acc_req && !acc_gnt) begin
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + SW'(1);
        end
        rd_valid_d = ram_cs && !ram_we;
        rd_tag_d   = acc_gnt ? TAG_ACC : TAG_CPU;
        acc_rvalid = rd_valid_q && (rd_tag_q == TAG_ACC);
        acc_rdata  = ram_rdata;
        hold_d     = hold_q;
        if (rd_valid_q && (rd_tag_q == TAG_CPU)) begin
            hold_d = ram_rdata;
        end
        cpu_rdata = hold_d;
    end

    // State registers, all cleared asynchronously so in-flight reads are lost
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= CPU_PRI;
            starve_q   <= '0;
            burst_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_tag_q   <= TAG_CPU;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            burst_q    <= burst_d;
            rd_valid_q <= rd_valid_d;
            rd_tag_q   <= rd_tag_d;
            hold_q     <= hold_d;
        end
    end

endmodule

// File: tb/tb_qoi_mem_arbiter.sv
// Self-checking bench for qoi_mem_arbiter: directed vector table, locked
// burst and mid-cycle reset sequences, then randomized traffic against a
// behavioural reference model with its own copy of the buffer contents.
module tb_qoi_mem_arbiter;

    localparam int ADDR_W     = 10;
    localparam int STARVE_MAX = 4;
    localparam int BURST_MAX  = 8;

    logic              clk;
    logic              rst;
    logic              cpu_req, cpu_we, acc_req, acc_we, acc_lock;
    logic [ADDR_W-1:0] cpu_addr, acc_addr;
    logic [7:0]        cpu_wdata, acc_wdata;
    logic [7:0]        cpu_rdata, acc_rdata, ram_wdata, ram_rdata;
    logic              cpu_rdy, acc_gnt, acc_rvalid, ram_cs, ram_we, conflict;
    logic [ADDR_W-1:0] ram_addr;

    qoi_mem_arbiter #(
        .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX), .BURST_MAX(BURST_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
        .acc_req(acc_req), .acc_we(acc_we), .acc_lock(acc_lock),
        .acc_addr(acc_addr), .acc_wdata(acc_wdata), .acc_gnt(acc_gnt),
        .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .conflict(conflict)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External synchronous RAM, loaded with a known pattern on the first edge
    logic [7:0] ram_mem [1024];
    bit         ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 1024; i++) ram_mem[i] <= 8'((i * 7) + 3);
            ram_loaded <= 1'b1;
        end else if (ram_cs) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    typedef struct {
        logic       cq, cw;
        logic [9:0] ca;
        logic [7:0] cd;
        logic       aq, aw, al;
        logic [9:0] aa;
        logic [7:0] ad;
        logic       e_gnt, e_rdy, e_cs;
        logic [9:0] e_addr;
        logic       e_rv, chk_rd;
        logic [7:0] e_rd;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // Reference model state: denials since last accelerator grant, grants in
    // the current locked burst, an owed CPU slot, and the pending read return
    logic [7:0] ref_mem [1024];
    int         m_denials, m_burst, m_ret;
    bit         m_slot, m_stalled;
    logic [7:0] m_ret_data, m_hold;

    function automatic vec_t mk(logic cq, logic cw, logic [9:0] ca, logic [7:0] cd,
                                logic aq, logic aw, logic al, logic [9:0] aa, logic [7:0] ad,
                                logic e_gnt, logic e_rdy, logic e_cs, logic [9:0] e_addr,
                                logic e_rv, logic chk_rd, logic [7:0] e_rd);
        vec_t v;
        v.cq = cq; v.cw = cw; v.ca = ca; v.cd = cd;
        v.aq = aq; v.aw = aw; v.al = al; v.aa = aa; v.ad = ad;
        v.e_gnt = e_gnt; v.e_rdy = e_rdy; v.e_cs = e_cs; v.e_addr = e_addr;
        v.e_rv = e_rv; v.chk_rd = chk_rd; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic checkOutput(string name, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(vec_t v);
        cpu_req = v.cq; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
        acc_req = v.aq; acc_we = v.aw; acc_lock = v.al; acc_addr = v.aa; acc_wdata = v.ad;
    endtask

    task automatic modelReset();
        m_denials = 0; m_burst = 0; m_slot = 0; m_stalled = 0;
        m_ret = 0; m_ret_data = 8'h00; m_hold = 8'h00;
    endtask

    // Decide this cycle's winner from the rules, compare, then advance
    task automatic modelStep();
        int win = 0;
        int nburst = 0;
        bit nslot = 0;
        if (m_slot) begin
            if (cpu_req) win = 1;
        end else if (m_burst > 0 && acc_req && acc_lock) begin
            if (m_burst == BURST_MAX && cpu_req) begin
                win = 1;
            end else begin
                win = 2;
                nburst = (m_burst < BURST_MAX) ? m_burst + 1 : BURST_MAX;
                if (nburst == BURST_MAX && cpu_req) begin
                    nslot = 1;
                    nburst = 0;
                end
            end
        end else if (acc_req && (!cpu_req || m_denials == STARVE_MAX)) begin
            win = 2;
            if (acc_lock) nburst = 1;
        end else if (cpu_req) begin
            win = 1;
        end

        checkOutput("m_acc_gnt", acc_gnt, (win == 2));
        checkOutput("m_cpu_rdy", cpu_rdy, !(cpu_req && win == 2));
        checkOutput("m_ram_cs", ram_cs, (win != 0));
        checkOutput("m_conflict", conflict, cpu_req & acc_req);
        if (win != 0) begin
            checkOutput("m_ram_we", ram_we, (win == 2) ? acc_we : cpu_we);
            checkOutput("m_ram_addr", ram_addr, (win == 2) ? acc_addr : cpu_addr);
            if (((win == 2) ? acc_we : cpu_we) == 1'b1)
                checkOutput("m_ram_wdata", ram_wdata, (win == 2) ? acc_wdata : cpu_wdata);
        end
        checkOutput("m_acc_rvalid", acc_rvalid, (m_ret == 2));
        if (m_ret == 2) checkOutput("m_acc_rdata", acc_rdata, m_ret_data);
        if (m_ret == 1) m_hold = m_ret_data;
        checkOutput("m_cpu_rdata", cpu_rdata, m_hold);

        m_ret = 0;
        if (win != 0) begin
            logic       we;
            logic [9:0] a;
            logic [7:0] d;
            we = (win == 2) ? acc_we : cpu_we;
            a  = (win == 2) ? acc_addr : cpu_addr;
            d  = (win == 2) ? acc_wdata : cpu_wdata;
            if (we) begin
                ref_mem[a] = d;
            end else begin
                m_ret = win;
                m_ret_data = ref_mem[a];
            end
        end
        m_denials = (acc_req && win != 2) ? ((m_denials < STARVE_MAX) ? m_denials + 1 : STARVE_MAX) : 0;
        m_burst   = nburst;
        m_slot    = nslot;
        m_stalled = cpu_req && (win == 2);
    endtask

    vec_t tbl[17];
    vec_t v, prev;

    initial begin
        int acc_cnt, run;
        bit run_ended;

        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'((i * 7) + 3);

        // C = CPU wins, A = accelerator wins (cpu stalled), both read continuously
        tbl[0]  = mk(0,0,10'h000,8'h00, 0,0,0,10'h000,8'h00, 0,1,0,10'h000, 0,0,8'h00);
        tbl[1]  = mk(1,0,10'h005,8'h00, 0,0,0,10'h000,8'h00, 0,1,1,10'h005, 0,0,8'h00);
        tbl[2]  = mk(0,0,10'h000,8'h00, 0,0,0,10'h000,8'h00, 0,1,0,10'h000, 0,1,8'h26);
        tbl[3]  = mk(0,0,10'h000,8'h00, 1,1,0,10'h3FF,8'hA5, 1,1,1,10'h3FF, 0,0,8'h00);
        tbl[4]  = mk(1,0,10'h3FF,8'h00, 0,0,0,10'h000,8'h00, 0,1,1,10'h3FF, 0,0,8'h00);
        tbl[5]  = mk(0,0,10'h000,8'h00, 0,0,0,10'h000,8'h00, 0,1,0,10'h000, 0,1,8'hA5);
        tbl[6]  = mk(1,0,10'h010,8'h00, 1,0,0,10'h020,8'h00, 0,1,1,10'h010, 0,0,8'h00);
        tbl[7]  = mk(1,0,10'h010,8'h00, 1,0,0,10'h020,8'h00, 0,1,1,10'h010, 0,1,8'h73);
        tbl[8]  = mk(1,0,10'h010,8'h00, 1,0,0,10'h020,8'h00, 0,1,1,10'h010, 0,0,8'h00);
        tbl[9]  = mk(1,0,10'h010,8'h00, 1,0,0,10'h020,8'h00, 0,1,1,10'h010, 0,0,8'h00);
        tbl[10] = mk(1,0,10'h010,8'h00, 1,0,0,10'h020,8'h00, 1,0,1,10'h020, 0,0,8'h00);
        tbl[11] = mk(1,0,10'h010,8'h00, 1,0,0,10'h020,8'h00, 0,1,1,10'h010, 1,0,8'h00);
        tbl[12] = mk(1,0,10'h010,8'h00, 1,0,0,10'h020,8'h00, 0,1,1,10'h010, 0,0,8'h00);
        tbl[13] = mk(1,0,10'h010,8'h00, 1,0,0,10'h020,8'h00, 0,1,1,10'h010, 0,0,8'h00);
        tbl[14] = mk(1,0,10'h010,8'h00, 1,0,0,10'h020,8'h00, 0,1,1,10'h010, 0,0,8'h00);
        tbl[15] = mk(1,0,10'h010,8'h00, 1,0,0,10'h020,8'h00, 1,0,1,10'h020, 0,0,8'h00);
        tbl[16] = mk(0,0,10'h000,8'h00, 0,0,0,10'h000,8'h00, 0,1,0,10'h000, 1,0,8'h00);

        // Reset held with both requesters active: grants must be suppressed
        rst = 1'b0;
        applyStimulus(mk(1,0,10'h001,8'h00, 1,0,1,10'h002,8'h00, 0,0,0,10'h0, 0,0,8'h0));
        #1;
        checkOutput("reset_acc_gnt", acc_gnt, 0);
        checkOutput("reset_ram_cs", ram_cs, 0);
        checkOutput("reset_cpu_rdy", cpu_rdy, 1);
        checkOutput("reset_acc_rvalid", acc_rvalid, 0);
        checkOutput("reset_cpu_rdata", cpu_rdata, 0);
        checkOutput("reset_conflict", conflict, 1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(tbl[0]);
        rst = 1'b1;
        modelReset();
        @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            applyStimulus(tbl[i]);
            #5;
            checkOutput($sformatf("vec%0d_gnt", i), acc_gnt, tbl[i].e_gnt);
            checkOutput($sformatf("vec%0d_rdy", i), cpu_rdy, tbl[i].e_rdy);
            checkOutput($sformatf("vec%0d_cs", i), ram_cs, tbl[i].e_cs);
            if (tbl[i].e_cs) checkOutput($sformatf("vec%0d_addr", i), ram_addr, tbl[i].e_addr);
            checkOutput($sformatf("vec%0d_rvalid", i), acc_rvalid, tbl[i].e_rv);
            if (tbl[i].chk_rd) checkOutput($sformatf("vec%0d_rdata", i), cpu_rdata, tbl[i].e_rd);
            modelStep();
            @(posedge clk);
            #1;
        end

        // Locked accelerator burst of 12 reads against a continuously requesting CPU
        acc_cnt = 0;
        run = 0;
        run_ended = 0;
        for (int c = 0; c < 40 && acc_cnt < 12; c++) begin
            applyStimulus(mk(1,0,10'h040,8'h00, 1,0,1,10'(32'h100 + acc_cnt),8'h00,
                             0,0,0,10'h0, 0,0,8'h0));
            #5;
            if (acc_gnt) begin
                acc_cnt++;
                if (!run_ended) run++;
            end else if (run > 0 && !run_ended) begin
                run_ended = 1;
                checkOutput("burst_cpu_slot", ram_cs && cpu_rdy && ram_addr == 10'h040, 1);
            end
            modelStep();
            @(posedge clk);
            #1;
        end
        checkOutput("burst_run_len", run, BURST_MAX);
        checkOutput("burst_slot_seen", run_ended, 1);
        checkOutput("burst_acc_grants", acc_cnt, 12);

        applyStimulus(tbl[0]);
        #5;
        modelStep();
        @(posedge clk);
        #1;

        // Reset mid-cycle with an accelerator read in flight and the CPU waiting
        applyStimulus(mk(0,0,10'h055,8'h00, 1,0,1,10'h0AA,8'h00, 0,0,0,10'h0, 0,0,8'h0));
        #5;
        checkOutput("pre_rst_acc_gnt", acc_gnt, 1);
        modelStep();
        @(posedge clk);
        #1;
        applyStimulus(mk(1,0,10'h055,8'h00, 1,0,1,10'h0AB,8'h00, 0,0,0,10'h0, 0,0,8'h0));
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midrst_acc_gnt", acc_gnt, 0);
        checkOutput("midrst_ram_cs", ram_cs, 0);
        checkOutput("midrst_acc_rvalid", acc_rvalid, 0);
        checkOutput("midrst_cpu_rdy", cpu_rdy, 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        modelReset();
        #3;
        checkOutput("post_rst_cpu_first", ram_cs && !acc_gnt && ram_addr == 10'h055, 1);
        checkOutput("post_rst_no_rvalid", acc_rvalid, 0);
        modelStep();
        @(posedge clk);
        #1;

        // Randomized traffic; a stalled CPU keeps its request unchanged
        prev = tbl[0];
        for (int c = 0; c < 400; c++) begin
            v = prev;
            if (!m_stalled) begin
                v.cq = ($urandom_range(0, 2) != 0);
                v.cw = ($urandom_range(0, 3) == 0);
                v.ca = 10'($urandom);
                v.cd = 8'($urandom);
            end
            v.aq = ($urandom_range(0, 2) != 0);
            v.aw = ($urandom_range(0, 3) == 0);
            v.al = ($urandom_range(0, 3) != 0);
            v.aa = 10'($urandom);
            v.ad = 8'($urandom);
            prev = v;
            applyStimulus(v);
            #5;
            modelStep();
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
